// File: rtl/calc1_pkg.sv
// -----------------------------------------------------------------------------
// calc1_pkg
// Shared definitions for the calc1 channel: command and response codes, the
// requester state encoding and the captured-result record.
// No ports (package).
// -----------------------------------------------------------------------------
package calc1_pkg;

    // Command codes on req_cmd_in
    localparam logic [0:3] CMD_NOP = 4'd0;
    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
    localparam logic [0:3] CMD_LSH = 4'd5;
    localparam logic [0:3] CMD_RSH = 4'd6;

    // Response codes on out_resp
    localparam logic [0:1] RESP_NONE = 2'd0;
    localparam logic [0:1] RESP_SUCC = 2'd1;
    localparam logic [0:1] RESP_INOF = 2'd2;
    localparam logic [0:1] RESP_IERR = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StWait,
        StResult,
        StDead
    } req_state_e;

    typedef struct packed {
        logic [0:1]  resp;
        logic [0:31] data;
        logic        timeout;
    } req_result_t;

    // Results that leave the channel unusable until reset
    function automatic logic is_fatal(input req_result_t r);
        return r.timeout || (r.resp == RESP_INOF) || (r.resp == RESP_IERR);
    endfunction

endpackage

// File: rtl/calc1_req_timer.sv
// -----------------------------------------------------------------------------
// calc1_req_timer
// Saturating up-counter used to time the WAIT phase of a calc1 request.
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   i_clr   synchronous clear to zero
//   i_en    count enable
//   o_next  value the counter takes on the next enabled edge (saturated)
//   o_tc    terminal count: the next enabled edge reaches LIMIT
// -----------------------------------------------------------------------------
module calc1_req_timer #(
    parameter int unsigned LIMIT = 64,
    parameter int unsigned W     = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_next,
    output logic         o_tc
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_next;

    assign w_next = (&r_count) ? r_count : r_count + W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_next;
        end
    end

    assign o_next = w_next;
    assign o_tc   = (32'(w_next) >= LIMIT);

endmodule

// File: rtl/calc1_requester.sv
// -----------------------------------------------------------------------------
// calc1_requester
// Initiator side of one calc1 channel port. Takes one host operation, drives
// the two-cycle request (cmd + operand 1, then operand 2), waits for the
// response or a timeout and hands the result back to the host.
//
// Optional macro CALC1_REQUESTER_LAT_STATS_EN adds lat_last / lat_max.
//
// Ports:
//   c_clk, reset            clock, synchronous active-high reset
//   op_valid/op_ready       host operation handshake; op_cmd, op_a, op_b
//   req_cmd_out/req_data_out request wires to the calculator
//   out_resp_in/out_data_in response wires from the calculator
//   res_valid/res_ready     result handshake; res_resp, res_data, res_timeout
//   dead                    channel halted after error or timeout
//   proto_err               sticky: response seen outside WAIT
//   lat_last, lat_max       (optional) WAIT cycles of last / slowest response
// -----------------------------------------------------------------------------
module calc1_requester
    import calc1_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned LAT_W          = 16
) (
    input  logic             c_clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [0:3]       op_cmd,
    input  logic [0:31]      op_a,
    input  logic [0:31]      op_b,
    output logic [0:3]       req_cmd_out,
    output logic [0:31]      req_data_out,
    input  logic [0:1]       out_resp_in,
    input  logic [0:31]      out_data_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [0:1]       res_resp,
    output logic [0:31]      res_data,
    output logic             res_timeout,
    output logic             dead,
    output logic             proto_err
`ifdef CALC1_REQUESTER_LAT_STATS_EN
    ,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_max
`endif
);

    req_state_e  r_state, w_state_next;
    logic        r_op_ready;
    logic [0:31] r_b, w_b_next;
    logic [0:3]  r_req_cmd, w_req_cmd_next;
    logic [0:31] r_req_data, w_req_data_next;
    req_result_t r_res, w_res_next;
    logic        r_res_valid, w_res_valid_next;
    logic        r_dead;
    logic        r_proto_err;

    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic [LAT_W-1:0] w_tmr_next;
    logic             w_tmr_tc;
    logic             w_capture;
    logic             w_spurious;

    calc1_req_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (LAT_W)
    ) u_timer (
        .i_clk  (c_clk),
        .i_rst  (reset),
        .i_clr  (w_tmr_clr),
        .i_en   (w_tmr_en),
        .o_next (w_tmr_next),
        .o_tc   (w_tmr_tc)
    );

    assign w_spurious = (out_resp_in != RESP_NONE) && (r_state != StWait);

    always_comb begin
        w_state_next     = r_state;
        w_b_next         = r_b;
        w_req_cmd_next   = '0;
        w_req_data_next  = '0;
        w_res_next       = r_res;
        w_res_valid_next = r_res_valid;
        w_tmr_clr        = 1'b0;
        w_tmr_en         = 1'b0;
        w_capture        = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (op_valid && r_op_ready) begin
                    w_b_next = op_b;
                    if (op_cmd == CMD_NOP) begin
                        // NOP never reaches the wire; report it as a timeout
                        w_res_next       = '{resp: RESP_NONE, data: '0, timeout: 1'b1};
                        w_res_valid_next = 1'b1;
                        w_state_next     = StResult;
                    end else begin
                        w_req_cmd_next  = op_cmd;
                        w_req_data_next = op_a;
                        w_state_next    = StCmd;
                    end
                end
            end
            StCmd: begin
                w_req_data_next = r_b;
                w_state_next    = StData;
            end
            StData: begin
                w_tmr_clr    = 1'b1;
                w_state_next = StWait;
            end
            StWait: begin
                w_tmr_en = 1'b1;
                // A response on the terminal-count cycle still wins
                if (out_resp_in != RESP_NONE) begin
                    w_res_next       = '{resp: out_resp_in, data: out_data_in, timeout: 1'b0};
                    w_res_valid_next = 1'b1;
                    w_capture        = 1'b1;
                    w_state_next     = StResult;
                end else if (w_tmr_tc) begin
                    w_res_next       = '{resp: RESP_NONE, data: '0, timeout: 1'b1};
                    w_res_valid_next = 1'b1;
                    w_state_next     = StResult;
                end
            end
            StResult: begin
                if (r_res_valid && res_ready) begin
                    w_res_valid_next = 1'b0;
                    w_state_next     = is_fatal(r_res) ? StDead : StIdle;
                end
            end
            StDead: begin
                w_state_next = StDead;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_op_ready  <= 1'b0;
            r_b         <= '0;
            r_req_cmd   <= '0;
            r_req_data  <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_dead      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            // Ready/dead are registered views of the state being entered
            r_op_ready  <= (w_state_next == StIdle);
            r_dead      <= (w_state_next == StDead);
            r_b         <= w_b_next;
            r_req_cmd   <= w_req_cmd_next;
            r_req_data  <= w_req_data_next;
            r_res       <= w_res_next;
            r_res_valid <= w_res_valid_next;
            r_proto_err <= r_proto_err | w_spurious;
        end
    end

    assign op_ready     = r_op_ready;
    assign req_cmd_out  = r_req_cmd;
    assign req_data_out = r_req_data;
    assign res_valid    = r_res_valid;
    assign res_resp     = r_res.resp;
    assign res_data     = r_res.data;
    assign res_timeout  = r_res.timeout;
    assign dead         = r_dead;
    assign proto_err    = r_proto_err;

`ifdef CALC1_REQUESTER_LAT_STATS_EN
    logic [LAT_W-1:0] r_lat_last;
    logic [LAT_W-1:0] r_lat_max;

    // w_tmr_next on the capture edge is the number of WAIT cycles including this one
    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_lat_last <= '0;
            r_lat_max  <= '0;
        end else if (w_capture) begin
            r_lat_last <= w_tmr_next;
            if (w_tmr_next > r_lat_max) begin
                r_lat_max <= w_tmr_next;
            end
        end
    end

    assign lat_last = r_lat_last;
    assign lat_max  = r_lat_max;
`else
    logic w_unused_tmr_next;
    assign w_unused_tmr_next = ^w_tmr_next;
`endif

endmodule

// File: tb/tb_calc1_requester.sv
module tb_calc1_requester;
    import calc1_pkg::*;

    localparam int unsigned TMO = 16;

    logic        c_clk;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [0:3]  op_cmd;
    logic [0:31] op_a;
    logic [0:31] op_b;
    logic [0:3]  req_cmd_out;
    logic [0:31] req_data_out;
    logic [0:1]  out_resp_in;
    logic [0:31] out_data_in;
    logic        res_valid;
    logic        res_ready;
    logic [0:1]  res_resp;
    logic [0:31] res_data;
    logic        res_timeout;
    logic        dead;
    logic        proto_err;
`ifdef CALC1_REQUESTER_LAT_STATS_EN
    logic [15:0] lat_last;
    logic [15:0] lat_max;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    req_result_t sb[$];

    calc1_requester #(
        .TIMEOUT_CYCLES (TMO),
        .LAT_W          (16)
    ) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_cmd       (op_cmd),
        .op_a         (op_a),
        .op_b         (op_b),
        .req_cmd_out  (req_cmd_out),
        .req_data_out (req_data_out),
        .out_resp_in  (out_resp_in),
        .out_data_in  (out_data_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_resp     (res_resp),
        .res_data     (res_data),
        .res_timeout  (res_timeout),
        .dead         (dead),
        .proto_err    (proto_err)
`ifdef CALC1_REQUESTER_LAT_STATS_EN
        ,
        .lat_last     (lat_last),
        .lat_max      (lat_max)
`endif
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] resp, input logic [31:0] data, input logic to);
        req_result_t r;
        r.resp    = resp;
        r.data    = data;
        r.timeout = to;
        sb.push_back(r);
    endtask

    // Pop the oldest expected result and compare with what the DUT presents
    task automatic check_result(input string tag);
        req_result_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(res_valid), 1);
            check({tag, "_resp"}, 32'(res_resp), 32'(e.resp));
            check({tag, "_data"}, 32'(res_data), 32'(e.data));
            check({tag, "_timeout"}, 32'(res_timeout), 32'(e.timeout));
        end
    endtask

    // Handshake an op and follow it to the first WAIT cycle
    task automatic issue_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op_cmd   = cmd;
        op_a     = a;
        op_b     = b;
        tick();
        op_valid = 1'b0;
        check("cmd_phase_cmd", 32'(req_cmd_out), 32'(cmd));
        check("cmd_phase_data", 32'(req_data_out), a);
        check("cmd_phase_ready", 32'(op_ready), 0);
        tick();
        check("data_phase_cmd", 32'(req_cmd_out), 0);
        check("data_phase_data", 32'(req_data_out), b);
        tick();
        check("wait_req_data", 32'(req_data_out), 0);
    endtask

    // Respond during WAIT cycle n (1 = first WAIT cycle)
    task automatic respond(input int n, input logic [1:0] resp, input logic [31:0] data);
        for (int i = 1; i < n; i++) begin
            tick();
            check("early_valid", 32'(res_valid), 0);
        end
        out_resp_in = resp;
        out_data_in = data;
        tick();
        out_resp_in = '0;
        out_data_in = '0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("consumed_valid", 32'(res_valid), 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_ready", 32'(op_ready), 1);
        check("post_reset_dead", 32'(dead), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset       = 1'b1;
        op_valid    = 1'b0;
        op_cmd      = '0;
        op_a        = '0;
        op_b        = '0;
        out_resp_in = '0;
        out_data_in = '0;
        res_ready   = 1'b0;
        tick();
        tick();
        check("rst_op_ready", 32'(op_ready), 0);
        check("rst_req_cmd", 32'(req_cmd_out), 0);
        check("rst_req_data", 32'(req_data_out), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_dead", 32'(dead), 0);
        check("rst_proto_err", 32'(proto_err), 0);
        reset = 1'b0;
        tick();
        check("idle_op_ready", 32'(op_ready), 1);

        // ADD, minimum latency path is exercised later; here respond in WAIT cycle 2
        push(RESP_SUCC, 32'd12, 1'b0);
        issue_op(CMD_ADD, 32'd5, 32'd7);
        respond(2, RESP_SUCC, 32'd12);
        check_result("add");
        check("add_dead", 32'(dead), 0);
        consume();
        check("add_ready_after", 32'(op_ready), 1);

        // Minimum latency: response in first WAIT cycle -> res_valid 4 cycles after accept
        push(RESP_SUCC, 32'hA5A5_0001, 1'b0);
        issue_op(CMD_RSH, 32'h1, 32'h2);
        respond(1, RESP_SUCC, 32'hA5A5_0001);
        check_result("minlat");
        consume();

        // Response on the terminal-count cycle beats the timeout
        push(RESP_SUCC, 32'd99, 1'b0);
        issue_op(CMD_ADD, 32'd90, 32'd9);
        respond(int'(TMO), RESP_SUCC, 32'd99);
        check_result("tc_race");
        consume();
        check("tc_race_ready", 32'(op_ready), 1);

        // Back-pressure on LSH
        push(RESP_SUCC, 32'd16, 1'b0);
        issue_op(CMD_LSH, 32'd1, 32'd4);
        respond(2, RESP_SUCC, 32'd16);
        check_result("lsh");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(res_valid), 1);
            check("bp_resp", 32'(res_resp), 1);
            check("bp_data", 32'(res_data), 32'd16);
            check("bp_ready", 32'(op_ready), 0);
        end
        consume();
        check("bp_ready_after", 32'(op_ready), 1);

        // SUB underflow -> dead
        push(RESP_INOF, 32'hFFFF_FFFE, 1'b0);
        issue_op(CMD_SUB, 32'd3, 32'd5);
        respond(3, RESP_INOF, 32'hFFFF_FFFE);
        check_result("sub");
        consume();
        check("sub_dead", 32'(dead), 1);
        check("sub_ready", 32'(op_ready), 0);
        tick();
        check("dead_req_cmd", 32'(req_cmd_out), 0);
        pulse_reset();

        // Timeout: res_valid exactly TMO cycles after entering WAIT
        push(RESP_NONE, 32'd0, 1'b1);
        issue_op(CMD_ADD, 32'd1, 32'd1);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (res_valid) begin
                cyc = i;
                break;
            end
        end
        check("timeout_cycles", 32'(cyc), TMO);
        check_result("timeout");
        consume();
        check("timeout_dead", 32'(dead), 1);
        check("timeout_ready", 32'(op_ready), 0);
        pulse_reset();

        // NOP: accepted, no request, immediate timeout result
        push(RESP_NONE, 32'd0, 1'b1);
        op_valid = 1'b1;
        op_cmd   = CMD_NOP;
        op_a     = 32'd77;
        op_b     = 32'd88;
        tick();
        op_valid = 1'b0;
        check("nop_req_cmd", 32'(req_cmd_out), 0);
        check("nop_req_data", 32'(req_data_out), 0);
        check_result("nop");
        consume();
        check("nop_dead", 32'(dead), 1);
        pulse_reset();

        // Reset while in WAIT: operation vanishes
        issue_op(CMD_ADD, 32'd2, 32'd2);
        tick();
        reset = 1'b1;
        tick();
        check("midrst_ready", 32'(op_ready), 0);
        check("midrst_req_cmd", 32'(req_cmd_out), 0);
        check("midrst_req_data", 32'(req_data_out), 0);
        check("midrst_res_data", 32'(res_data), 0);
        check("midrst_res_valid", 32'(res_valid), 0);
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid) cyc++;
        end
        check("midrst_no_result", 32'(cyc), 0);
        check("midrst_proto_clear", 32'(proto_err), 0);
        out_resp_in = RESP_SUCC;
        tick();
        out_resp_in = '0;
        tick();
        check("spurious_proto_err", 32'(proto_err), 1);
        check("spurious_no_valid", 32'(res_valid), 0);
        check("spurious_ready", 32'(op_ready), 1);

`ifdef CALC1_REQUESTER_LAT_STATS_EN
        pulse_reset();
        check("lat_rst_last", 32'(lat_last), 0);
        push(RESP_SUCC, 32'd3, 1'b0);
        issue_op(CMD_ADD, 32'd1, 32'd2);
        respond(3, RESP_SUCC, 32'd3);
        check_result("lat3");
        check("lat_last_3", 32'(lat_last), 3);
        consume();
        push(RESP_SUCC, 32'd9, 1'b0);
        issue_op(CMD_ADD, 32'd4, 32'd5);
        respond(9, RESP_SUCC, 32'd9);
        check_result("lat9");
        consume();
        push(RESP_SUCC, 32'd5, 1'b0);
        issue_op(CMD_ADD, 32'd2, 32'd3);
        respond(5, RESP_SUCC, 32'd5);
        check_result("lat5");
        consume();
        check("lat_last", 32'(lat_last), 5);
        check("lat_max", 32'(lat_max), 9);
`endif

        check("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/calc1_requester.md
Name: calc1_requester

Overview:
- Initiator side of the calc1 channel protocol.
- Accepts one operation at a time from a host-side valid/ready interface and drives the two-cycle request onto one calculator port (command plus operand 1, then operand 2).
- Waits for the port response, then returns response and data to the host.
- One instance per calculator port (four total). Used as the stimulus driver in benches and as the port front-end in integration.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in WAIT before declaring timeout (range 2..65535).
- LAT_W, 16, width of the wait and latency counters.

Ports:
- c_clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  host operation valid.
- op_ready  out  1  block can accept an operation.
- op_cmd  in  [0:3]  command (1 ADD, 2 SUB, 5 LSH, 6 RSH).
- op_a  in  [0:31]  operand 1.
- op_b  in  [0:31]  operand 2.
- req_cmd_out  out  [0:3]  to calculator req_cmd_in.
- req_data_out  out  [0:31]  to calculator req_data_in.
- out_resp_in  in  [0:1]  from calculator out_resp.
- out_data_in  in  [0:31]  from calculator out_data.
- res_valid  out  1  result available.
- res_ready  in  1  host consumes result.
- res_resp  out  [0:1]  captured response code.
- res_data  out  [0:31]  captured result data.
- res_timeout  out  1  result is a timeout (res_resp=0, res_data=0).
- dead  out  1  channel halted after error or timeout.
- proto_err  out  1  sticky; response seen outside WAIT.

Behaviour:
- All outputs are registered.
- Reset values: op_ready=0 during reset, 1 the cycle after; req_cmd_out=0; req_data_out=0; res_*=0; dead=0; proto_err=0; state IDLE.
- Reset mid-operation abandons the operation silently. No result is produced.
- States:
  - IDLE:
    - op_ready=1.
    - Handshake op_valid&&op_ready at posedge latches cmd/a/b and goes to CMD.
  - CMD (1 cycle):
    - req_cmd_out=op_cmd, req_data_out=op_a.
    - Goes to DATA.
  - DATA (1 cycle):
    - req_cmd_out=0, req_data_out=op_b.
    - Goes to WAIT.
    - Wait counter cleared.
  - WAIT:
    - req_cmd_out=0, req_data_out=0.
    - Counter increments each cycle.
    - out_resp_in!=0 captures resp/data into res_*, sets res_valid, goes to RESULT.
    - Counter reaching TIMEOUT_CYCLES with no response sets res_valid=1, res_timeout=1, res_resp=0, res_data=0, goes to RESULT.
  - RESULT:
    - res_* held stable while res_ready=0.
    - On res_valid&&res_ready: res_valid clears.
      - If resp was 2 or 3, or timeout: go to DEAD.
      - Else: go to IDLE.
  - DEAD:
    - dead=1, op_ready=0, request outputs 0.
    - Only reset exits.
- Timing and latency:
  - Accepting an op in cycle N puts cmd on the wire in N+1 and operand 2 in N+2.
  - Minimum accept-to-res_valid latency is 4 cycles (response in the first WAIT cycle).
  - No back-to-back overlap: op_ready=0 from CMD through RESULT.
- Invalid op_cmd values (0, 3, 4, 7..15):
  - op_cmd=0 is accepted, but the block returns a timeout result immediately instead of driving NOP (no request issued).
  - Other invalid codes are driven as-is; the calculator is expected to return resp 2.
- Spurious response (out_resp_in!=0 in IDLE, CMD, DATA, RESULT or DEAD):
  - Sets proto_err (sticky until reset).
  - The response is otherwise ignored.
- Response arriving in the same cycle the counter hits TIMEOUT_CYCLES: the response wins, no timeout.

Optional Feature:
- Macro: CALC1_REQUESTER_LAT_STATS_EN.
- Defined:
  - Adds outputs lat_last [LAT_W-1:0] (WAIT cycles of the most recent non-timeout result) and lat_max [LAT_W-1:0] (running maximum).
  - Both update on the response capture edge and reset to 0.
  - Counters saturate at all-ones.
- Undefined: the ports and logic are absent.

Decomposition:
- Package calc1_pkg holds:
  - command localparams CMD_NOP/ADD/SUB/LSH/RSH (0/1/2/5/6);
  - response localparams RESP_NONE/SUCC/INOF/IERR (0..3);
  - the requester state enum;
  - a typedef for the {resp, data, timeout} result struct.
- The wait/latency counter is a natural sub-module, calc1_req_timer: clear, enable, saturating count, terminal-count flag.

Test Plan:
- ADD: op 1, a=5, b=7; calculator responds resp=1, data=12 two cycles after DATA -> res_valid with res_resp=1, res_data=12, dead=0, op_ready=1 after the handshake.
- SUB underflow: op 2, a=3, b=5; calculator resp=2 -> res_resp=2; after res_ready, dead=1 and op_ready=0; reset pulse -> op_ready=1, dead=0.
- Timeout: TIMEOUT_CYCLES=16, no response -> res_valid exactly 16 cycles after entering WAIT with res_timeout=1, res_resp=0; then dead=1.
- Back-pressure: LSH a=1, b=4, resp=1, data=16 with res_ready low for 10 cycles -> res_* stable throughout, op_ready stays 0, consumed on the first res_ready.
- Reset while in WAIT: no res_valid ever appears, all outputs return to reset values; a later spurious resp=1 in IDLE sets proto_err=1.
- With CALC1_REQUESTER_LAT_STATS_EN: responses after 3, then 9, then 5 WAIT cycles -> lat_last=5, lat_max=9.
